// File: rtl/power_spectrum_buffer.sv
// Multi-bank frame buffer for per-frame FFT power spectra.
// Frames commit on wr_done_i and are read back and released oldest-first.
module power_spectrum_buffer #(
   parameter int NFFT         = 512,
   parameter int SAMPLE_WIDTH = 32,
   parameter int NUM_BANKS    = 2,
   parameter int ADDR_WIDTH   = $clog2(NFFT/2+1),
   parameter int CNT_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_i,
   input  logic                       wr_valid_i,
   input  logic [ADDR_WIDTH-1:0]      wr_ptr_i,
   input  logic [SAMPLE_WIDTH-1:0]    wr_data_i,
   input  logic                       wr_done_i,
   output logic                       frame_ready_o,
   output logic [$clog2(NUM_BANKS):0] occupancy_o,
   input  logic                       rd_en_i,
   input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
   output logic [SAMPLE_WIDTH-1:0]    rd_data_o,
   output logic                       rd_valid_o,
   input  logic                       rd_release_i,
   output logic [CNT_WIDTH-1:0]       frame_count_o,
   output logic [CNT_WIDTH-1:0]       drop_count_o,
   output logic                       overflow_o,
   output logic                       short_frame_o,
   output logic                       ptr_err_o
);

   localparam int NBINS  = NFFT/2+1;
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int OCC_W  = $clog2(NUM_BANKS)+1;
   localparam logic [ADDR_WIDTH-1:0] NBINS_A = ADDR_WIDTH'(NBINS);
   localparam logic [OCC_W-1:0]      FULL    = OCC_W'(NUM_BANKS);

   localparam logic FILL = 1'b0;
   localparam logic DROP = 1'b1;

   logic [SAMPLE_WIDTH-1:0] mem [NUM_BANKS][NBINS];

   logic                  state;
   logic [BANK_W-1:0]     wr_bank;
   logic [BANK_W-1:0]     rd_bank;
   logic [ADDR_WIDTH-1:0] bin_cnt;

   logic                  ptr_ok;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  commit;
   logic                  rel;
   logic                  boundary;
   logic [ADDR_WIDTH-1:0] bin_inc;
   logic [OCC_W-1:0]      occ_next;

   always_comb begin
      ptr_ok   = wr_ptr_i < NBINS_A;
      wr_ok    = wr_valid_i && ptr_ok;
      rd_ok    = rd_en_i && frame_ready_o && (rd_addr_i < NBINS_A);
      bin_inc  = bin_cnt;
      if (wr_ok && bin_cnt != NBINS_A)
         bin_inc = bin_cnt + ADDR_WIDTH'(1);
      commit   = (state == FILL) && wr_done_i;
      rel      = rd_release_i && (occupancy_o != '0);
      occ_next = occupancy_o + OCC_W'(commit) - OCC_W'(rel);
      // Bin count keeps running while dropping so a partial frame is never
      // mistaken for a boundary.
      boundary = wr_done_i || (bin_cnt == '0 && !wr_valid_i);
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear_i && state == FILL && wr_ok)
         mem[wr_bank][wr_ptr_i] <= wr_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FILL;
         wr_bank       <= '0;
         rd_bank       <= '0;
         bin_cnt       <= '0;
         occupancy_o   <= '0;
         frame_ready_o <= 1'b0;
         rd_data_o     <= '0;
         rd_valid_o    <= 1'b0;
         frame_count_o <= '0;
         drop_count_o  <= '0;
         overflow_o    <= 1'b0;
         short_frame_o <= 1'b0;
         ptr_err_o     <= 1'b0;
      end else if (clear_i) begin
         state         <= FILL;
         wr_bank       <= '0;
         rd_bank       <= '0;
         bin_cnt       <= '0;
         occupancy_o   <= '0;
         frame_ready_o <= 1'b0;
         rd_data_o     <= '0;
         rd_valid_o    <= 1'b0;
         frame_count_o <= '0;
         drop_count_o  <= '0;
         overflow_o    <= 1'b0;
         short_frame_o <= 1'b0;
         ptr_err_o     <= 1'b0;
      end else begin
         rd_valid_o    <= rd_en_i;
         rd_data_o     <= rd_ok ? mem[rd_bank][rd_addr_i] : '0;
         occupancy_o   <= occ_next;
         frame_ready_o <= occ_next != '0;
         if (rel)
            rd_bank <= rd_bank + BANK_W'(1);
         if (wr_valid_i && !ptr_ok)
            ptr_err_o <= 1'b1;
         unique case (state)
            FILL: begin
               if (commit) begin
                  frame_count_o <= frame_count_o + CNT_WIDTH'(1);
                  if (bin_inc != NBINS_A)
                     short_frame_o <= 1'b1;
                  bin_cnt <= '0;
                  wr_bank <= wr_bank + BANK_W'(1);
                  if (occ_next == FULL)
                     state <= DROP;
               end else begin
                  bin_cnt <= bin_inc;
               end
            end
            DROP: begin
               if (wr_done_i) begin
                  drop_count_o <= drop_count_o + CNT_WIDTH'(1);
                  overflow_o   <= 1'b1;
                  bin_cnt      <= '0;
               end else begin
                  bin_cnt <= bin_inc;
               end
               if (boundary && occ_next < FULL)
                  state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_power_spectrum_buffer.sv
// Self-checking bench for power_spectrum_buffer.
// Reference model: a queue of committed frames plus a frame being filled.
module tb_power_spectrum_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_i = 1'b0;
   logic        wr_valid_i = 1'b0;
   logic [8:0]  wr_ptr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic        wr_done_i = 1'b0;
   logic        frame_ready_o;
   logic [1:0]  occupancy_o;
   logic        rd_en_i = 1'b0;
   logic [8:0]  rd_addr_i = '0;
   logic [31:0] rd_data_o;
   logic        rd_valid_o;
   logic        rd_release_i = 1'b0;
   logic [15:0] frame_count_o;
   logic [15:0] drop_count_o;
   logic        overflow_o;
   logic        short_frame_o;
   logic        ptr_err_o;

   power_spectrum_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ptr_i      (wr_ptr_i),
      .wr_data_i     (wr_data_i),
      .wr_done_i     (wr_done_i),
      .frame_ready_o (frame_ready_o),
      .occupancy_o   (occupancy_o),
      .rd_en_i       (rd_en_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .rd_release_i  (rd_release_i),
      .frame_count_o (frame_count_o),
      .drop_count_o  (drop_count_o),
      .overflow_o    (overflow_o),
      .short_frame_o (short_frame_o),
      .ptr_err_o     (ptr_err_o)
   );

   always #5 clk = ~clk;

   localparam int NB = 257;

   // bit 32 marks a bin written in this frame; other bins hold stale data
   typedef logic [32:0] ent_t;
   typedef ent_t frame_t [NB];

   frame_t      q[$];
   frame_t      cur;
   int          cnt;
   bit          dropping;
   logic [15:0] fcnt;
   logic [15:0] dcnt;
   logic        ovf;
   logic        shrt;
   logic        perr;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void clear_cur();
      foreach (cur[i]) cur[i] = '0;
   endfunction

   function automatic void model_reset();
      q.delete();
      clear_cur();
      cnt      = 0;
      dropping = 0;
      fcnt     = '0;
      dcnt     = '0;
      ovf      = 0;
      shrt     = 0;
      perr     = 0;
   endfunction

   function automatic void model_cycle(input logic v, input int p,
                                       input logic [31:0] d,
                                       input logic dn, input logic rl);
      if (v) begin
         if (p >= NB) perr = 1;
         else begin
            if (!dropping) cur[p] = {1'b1, d};
            if (cnt < NB) cnt++;
         end
      end
      if (rl && q.size() > 0) void'(q.pop_front());
      if (dn) begin
         if (!dropping) begin
            q.push_back(cur);
            fcnt++;
            if (cnt != NB) shrt = 1;
            clear_cur();
            if (q.size() == 2) dropping = 1;
         end else begin
            dcnt++;
            ovf = 1;
            if (q.size() < 2) dropping = 0;
         end
         cnt = 0;
      end else if (dropping && !v && cnt == 0 && q.size() < 2) begin
         dropping = 0;
      end
   endfunction

   task automatic check_out(input logic exp_rv);
      chk("frame_ready", 32'(frame_ready_o), 32'(q.size() != 0));
      chk("occupancy", 32'(occupancy_o), q.size());
      chk("frame_count", 32'(frame_count_o), 32'(fcnt));
      chk("drop_count", 32'(drop_count_o), 32'(dcnt));
      chk("overflow", 32'(overflow_o), 32'(ovf));
      chk("short_frame", 32'(short_frame_o), 32'(shrt));
      chk("ptr_err", 32'(ptr_err_o), 32'(perr));
      chk("rd_valid", 32'(rd_valid_o), 32'(exp_rv));
   endtask

   task automatic step(input logic v, input int p, input logic [31:0] d,
                       input logic dn, input logic re, input int ra,
                       input logic rl, input logic clr);
      ent_t   e;
      frame_t f;
      @(negedge clk);
      wr_valid_i   = v;
      wr_ptr_i     = 9'(p);
      wr_data_i    = d;
      wr_done_i    = dn;
      rd_en_i      = re;
      rd_addr_i    = 9'(ra);
      rd_release_i = rl;
      clear_i      = clr;
      e = '0;
      if (re && q.size() != 0 && ra < NB) begin
         f = q[0];
         e = f[ra];
      end else begin
         e = {1'b1, 32'h0};
      end
      @(posedge clk);
      if (clr) model_reset();
      else model_cycle(v, p, d, dn, rl);
      #1;
      check_out(re && !clr);
      if (re && !clr && e[32]) chk("rd_data", rd_data_o, e[31:0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic done();
      step(0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic rd(input int a);
      step(0, 0, 0, 0, 1, a, 0, 0);
   endtask

   task automatic release1();
      step(0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   // mode 0: ptr*3, 1: constant pat, 2: random
   task automatic frame(input int n, input int mode, input logic [31:0] pat);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d = (mode == 0) ? 32'(i * 3) : (mode == 1) ? pat : $urandom;
         step(1, i, d, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++) rd($urandom_range(0, NB - 1));
   endtask

   initial begin
      int rp;
      logic v, bad, dn, re, rl;
      int p;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_out(0);
      chk("reset rd_data", rd_data_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // single frame
      frame(NB, 0, 0);
      done();
      rd(100);
      rd(0);
      rd(256);
      release1();
      idle(1);

      // overflow
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         frame(NB, 2, 0);
         done();
         idle(1);
      end
      rd(5);
      rand_reads(3);
      release1();
      rd(5);
      rand_reads(3);
      idle(1);

      // recovery
      frame(NB, 1, 32'hA5A5A5A5);
      done();
      idle(1);
      rd(7);
      release1();
      rd(7);
      release1();
      idle(2);

      // short frame and bad pointer
      frame(200, 2, 0);
      done();
      step(1, 300, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      rd(300);
      rd(50);
      rd(199);
      release1();
      idle(1);

      // simultaneous commit and release at occupancy 1
      frame(NB, 2, 0);
      done();
      frame(NB, 2, 0);
      step(0, 0, 0, 1, 0, 0, 1, 0);
      rand_reads(4);
      release1();
      idle(1);

      // async reset mid-frame
      step(0, 0, 0, 0, 0, 0, 0, 1);
      frame(NB, 2, 0);
      done();
      release1();
      frame(121, 2, 0);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_out(0);
      chk("async rd_data", rd_data_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      frame(NB, 2, 0);
      done();
      rand_reads(5);
      release1();

      // synchronous clear mid-frame
      frame(NB, 2, 0);
      done();
      release1();
      frame(121, 2, 0);
      step(1, 121, $urandom, 0, 1, 3, 0, 1);
      frame(NB, 2, 0);
      done();
      rand_reads(5);
      release1();
      idle(2);

      // random traffic
      rp = 0;
      repeat (1500) begin
         bad = ($urandom_range(0, 15) == 0);
         dn  = (rp == NB) || ($urandom_range(0, 299) == 0);
         v   = (rp < NB) && ($urandom_range(0, 3) != 0);
         p   = bad ? int'($urandom_range(NB, 511)) : rp;
         re  = $urandom_range(0, 1) == 1;
         rl  = $urandom_range(0, 39) == 0;
         if (v && !bad) rp++;
         if (dn) rp = 0;
         step(v, p, $urandom, dn, re, $urandom_range(0, 259), rl, 0);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
